// File: rtl/hist_mon_pkg.sv
// Shared types and helpers for the histogram monitor: FSM state encoding,
// code-to-bin mapping and the saturating counter step.
package hist_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } hist_state_e;

  // Two's complement code to offset-binary bin index (flip the sign bit).
  function automatic logic [31:0] code2bin(input logic [31:0] code, input int width);
    return code ^ (32'd1 << (width - 1));
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hist_bin_array.sv
// 2^Nadc x Ncnt histogram bin storage with clear port, saturating increment
// port and a combinational read port that forwards a same-cycle increment.
module hist_bin_array
  import hist_mon_pkg::*;
#(
  parameter int Nadc = 6,
  parameter int Ncnt = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr_en,
  input  logic [Nadc-1:0] clr_addr,
  input  logic            inc_en,
  input  logic [Nadc-1:0] inc_addr,
  input  logic [Nadc-1:0] rd_addr,
  output logic [Ncnt-1:0] rd_data,
  output logic            sat_hit
);

  localparam int NBINS = 1 << Nadc;
  localparam logic [Ncnt-1:0] CNT_MAX = '1;

  logic [Ncnt-1:0] r_bins [NBINS];
  logic [Ncnt-1:0] w_cur;
  logic [Ncnt-1:0] w_inc_val;

  assign w_cur     = r_bins[inc_addr];
  assign w_inc_val = Ncnt'(sat_inc(32'(w_cur), 32'(CNT_MAX)));
  assign sat_hit   = inc_en && (w_cur == CNT_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NBINS; i++) r_bins[i] <= '0;
    end else if (clr_en) begin
      r_bins[clr_addr] <= '0;
    end else if (inc_en) begin
      r_bins[inc_addr] <= w_inc_val;
    end
  end

  // Forward the in-flight increment so a read never sees a stale count.
  assign rd_data = (inc_en && (inc_addr == rd_addr)) ? w_inc_val : r_bins[rd_addr];

endmodule

// File: rtl/hist_monitor.sv
// Histogram collector for one selected RX slice over 2^Nsamp_log2 samples.
// Define HIST_MINMAX_EN to track min_code/max_code; otherwise they read 0.
module hist_monitor
  import hist_mon_pkg::*;
#(
  parameter int Nti        = 4,
  parameter int Nadc       = 6,
  parameter int Ncnt       = 16,
  parameter int Nsamp_log2 = 20,
  localparam int SELW      = (Nti > 1) ? $clog2(Nti) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [Nti*Nadc-1:0]    din,
  input  logic                   din_valid,
  input  logic [SELW-1:0]        slice_sel,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   sat,
  output logic [Nsamp_log2:0]    sample_cnt,
  input  logic                   rd_req,
  input  logic [Nadc-1:0]        rd_addr,
  output logic                   rd_ack,
  output logic [Ncnt-1:0]        rd_data,
  output logic signed [Nadc-1:0] min_code,
  output logic signed [Nadc-1:0] max_code
);

  localparam logic [Nsamp_log2:0] NSAMP_M1 = (Nsamp_log2 + 1)'((1 << Nsamp_log2) - 1);

  hist_state_e r_state, w_state_nxt;
  logic [Nadc-1:0]     r_clr_addr;
  logic [SELW-1:0]     r_slice;
  logic [Nsamp_log2:0] r_sample_cnt;
  logic                r_sat, r_s1_vld, r_rd_ack;
  logic [Nadc-1:0]     r_s1_bin;
  logic [Ncnt-1:0]     r_rd_data, w_arr_rd;
  logic [Nadc-1:0]     w_code;
  logic                w_idle_like, w_busy, w_start_ok, w_accept, w_sat_hit;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_busy      = (r_state == ST_CLEAR) || (r_state == ST_ACCUM);
  assign w_start_ok  = start && !abort && w_idle_like;
  assign w_accept    = din_valid && !abort && (r_state == ST_ACCUM);
  assign w_code      = din[int'(r_slice)*Nadc +: Nadc];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (abort) w_state_nxt = ST_IDLE;
                else if (r_clr_addr == '1) w_state_nxt = ST_ACCUM;
      ST_ACCUM: if (abort) w_state_nxt = ST_IDLE;
                else if (w_accept && (r_sample_cnt == NSAMP_M1)) w_state_nxt = ST_DONE;
      ST_DONE:  if (w_start_ok) w_state_nxt = ST_CLEAR;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = w_busy;
    done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_clr_addr   <= '0;
      r_slice      <= '0;
      r_sample_cnt <= '0;
      r_sat        <= 1'b0;
      r_s1_vld     <= 1'b0;
      r_s1_bin     <= '0;
      r_rd_ack     <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      if (w_start_ok) begin
        r_clr_addr   <= '0;
        r_slice      <= slice_sel;
        r_sample_cnt <= '0;
        r_sat        <= 1'b0;
      end else begin
        if (r_state == ST_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
        if (w_accept)            r_sample_cnt <= r_sample_cnt + 1'b1;
        if (w_sat_hit)           r_sat <= 1'b1;
      end
      // Stage 1 of the accumulate pipeline; the bin array is stage 2.
      r_s1_vld <= w_accept;
      if (w_accept) r_s1_bin <= Nadc'(code2bin(32'(w_code), Nadc));
      r_rd_ack <= rd_req && w_idle_like;
      if (rd_req && w_idle_like) r_rd_data <= w_arr_rd;
    end
  end

  hist_bin_array #(.Nadc(Nadc), .Ncnt(Ncnt)) u_bins (
    .clk      (clk),
    .rstn     (rstn),
    .clr_en   (r_state == ST_CLEAR),
    .clr_addr (r_clr_addr),
    .inc_en   (r_s1_vld),
    .inc_addr (r_s1_bin),
    .rd_addr  (rd_addr),
    .rd_data  (w_arr_rd),
    .sat_hit  (w_sat_hit)
  );

  assign sat        = r_sat;
  assign sample_cnt = r_sample_cnt;
  assign rd_ack     = r_rd_ack;
  assign rd_data    = r_rd_data;

`ifdef HIST_MINMAX_EN
  localparam logic signed [Nadc-1:0] CODE_MAX  = Nadc'((1 << (Nadc - 1)) - 1);
  localparam logic signed [Nadc-1:0] CODE_NMAX = Nadc'(1 - (1 << (Nadc - 1)));

  logic signed [Nadc-1:0] r_min, r_max;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_min <= CODE_MAX;
      r_max <= CODE_NMAX;
    end else if (w_start_ok) begin
      r_min <= CODE_MAX;
      r_max <= CODE_NMAX;
    end else if (w_accept) begin
      if ($signed(w_code) < r_min) r_min <= w_code;
      if ($signed(w_code) > r_max) r_max <= w_code;
    end
  end

  assign min_code = r_min;
  assign max_code = r_max;
`else
  assign min_code = '0;
  assign max_code = '0;
`endif

endmodule

// File: tb/tb_hist_monitor.sv
// Directed bench for hist_monitor (Nti=4, Nadc=6, Nsamp_log2=4); a second
// instance with Ncnt=3 shares the stimulus to exercise bin saturation.
module tb_hist_monitor;

  logic clk = 1'b0;
  logic rstn;
  logic [23:0] din;
  logic din_valid, start, abort, rd_req;
  logic [1:0] slice_sel;
  logic [5:0] rd_addr;

  logic busy, done, sat, rd_ack;
  logic [4:0] sample_cnt;
  logic [15:0] rd_data;
  logic signed [5:0] min_code, max_code;

  logic busy_s, done_s, sat_s, rd_ack_s;
  logic [4:0] sample_cnt_s;
  logic [2:0] rd_data_s;
  logic signed [5:0] min_code_s, max_code_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hist_monitor #(.Nti(4), .Nadc(6), .Ncnt(16), .Nsamp_log2(4)) dut (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .slice_sel(slice_sel),
    .start(start), .abort(abort), .busy(busy), .done(done), .sat(sat),
    .sample_cnt(sample_cnt), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .min_code(min_code), .max_code(max_code)
  );

  hist_monitor #(.Nti(4), .Nadc(6), .Ncnt(3), .Nsamp_log2(4)) dut_s (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .slice_sel(slice_sel),
    .start(start), .abort(abort), .busy(busy_s), .done(done_s), .sat(sat_s),
    .sample_cnt(sample_cnt_s), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack_s),
    .rd_data(rd_data_s), .min_code(min_code_s), .max_code(max_code_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [23:0] mk_din(input logic [5:0] s2, input logic [5:0] oth);
    return {oth, s2, oth, oth};
  endfunction

  task automatic do_start(input logic [1:0] sel);
    slice_sel = sel;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = 0;
    while (!done && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic rd_bin(input logic [5:0] a, output logic [15:0] d, output logic [2:0] ds);
    rd_req = 1'b1;
    rd_addr = a;
    @(negedge clk);
    rd_req = 1'b0;
    chk("rd_ack", 32'(rd_ack), 32'd1);
    d = rd_data;
    ds = rd_data_s;
  endtask

  logic [15:0] d;
  logic [2:0] ds;
  int cyc;

  initial begin
    rstn = 1'b0; din = '0; din_valid = 1'b0; start = 1'b0; abort = 1'b0;
    rd_req = 1'b0; slice_sel = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_cnt", 32'(sample_cnt), 32'd0);
    chk("rst_ack", 32'(rd_ack), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Basic run: slice 2 = +5 (bin 37), others -7 (bin 25)
    do_start(2'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    din = mk_din(6'd5, 6'h39);
    din_valid = 1'b1;
    wait_done(200, cyc);
    din_valid = 1'b0;
    chk("t1_latency", 32'(cyc), 32'd80);
    chk("t1_cnt", 32'(sample_cnt), 32'd16);
    chk("t1_sat", 32'(sat), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);
    @(negedge clk);
    rd_bin(6'd37, d, ds);
    chk("t1_bin37", 32'(d), 32'd16);
    chk("t1s_bin37", 32'(ds), 32'd7);
    chk("t1s_sat", 32'(sat_s), 32'd1);
    rd_bin(6'd25, d, ds);
    chk("t1_bin25", 32'(d), 32'd0);

    // 50% valid: valid cycles carry -3 (bin 29), idle cycles +20 (bin 52)
    do_start(2'd2);
    for (int i = 0; i < 400 && !done; i++) begin
      din_valid = ~din_valid;
      din = din_valid ? mk_din(6'h3D, 6'd0) : mk_din(6'd20, 6'd0);
      @(negedge clk);
    end
    din_valid = 1'b0;
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_cnt", 32'(sample_cnt), 32'd16);
    @(negedge clk);
    rd_bin(6'd29, d, ds);
    chk("t2_bin29", 32'(d), 32'd16);
    rd_bin(6'd52, d, ds);
    chk("t2_bin52", 32'(d), 32'd0);

    // Saturation: 16 samples of code 0 (bin 32)
    do_start(2'd2);
    din = mk_din(6'd0, 6'd7);
    din_valid = 1'b1;
    wait_done(200, cyc);
    din_valid = 1'b0;
    @(negedge clk);
    rd_bin(6'd32, d, ds);
    chk("t3s_bin32", 32'(ds), 32'd7);
    chk("t3s_sat", 32'(sat_s), 32'd1);
    chk("t3_bin32", 32'(d), 32'd16);
    chk("t3_sat", 32'(sat), 32'd0);
    do_start(2'd1);
    chk("t3s_sat_clr", 32'(sat_s), 32'd0);
    chk("t3_done_clr", 32'(done), 32'd0);
    chk("t3_cnt_clr", 32'(sample_cnt), 32'd0);

    // Abort after 6 samples of +9 (bin 41) on slice 1; reads ignored while busy
    repeat (70) @(negedge clk);
    din = mk_din(6'd20, 6'd9);
    for (int i = 0; i < 6; i++) begin
      din_valid = 1'b1;
      rd_req = 1'b1;
      rd_addr = 6'd41;
      @(negedge clk);
      chk("t4_noack", 32'(rd_ack), 32'd0);
    end
    din_valid = 1'b0;
    rd_req = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_cnt", 32'(sample_cnt), 32'd6);
    rd_bin(6'd41, d, ds);
    chk("t4_bin41", 32'(d), 32'd6);
    chk("t4s_bin41", 32'(ds), 32'd6);
    rd_bin(6'd29, d, ds);
    chk("t4_bin29_clr", 32'(d), 32'd0);

    // start with abort in the same cycle: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("t4_sa_busy", 32'(busy), 32'd0);
    chk("t4_sa_cnt", 32'(sample_cnt), 32'd6);

    // start while busy ignored, then asynchronous reset mid-ACCUM
    do_start(2'd1);
    repeat (70) @(negedge clk);
    din_valid = 1'b1;
    repeat (3) @(negedge clk);
    din_valid = 1'b0;
    do_start(2'd1);
    chk("t5_busy_start", 32'(busy), 32'd1);
    chk("t5_cnt_kept", 32'(sample_cnt), 32'd3);
    #2 rstn = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_cnt", 32'(sample_cnt), 32'd0);
    chk("t5_data", 32'(rd_data), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rd_bin(6'd41, d, ds);
    chk("t5_bin41", 32'(d), 32'd0);

    // min/max over {-32, +31, 0} on slice 0
    do_start(2'd0);
    repeat (70) @(negedge clk);
    din_valid = 1'b1;
    din = mk_din(6'd0, 6'h20);
    @(negedge clk);
    din = mk_din(6'd0, 6'h1F);
    @(negedge clk);
    din = mk_din(6'd0, 6'h00);
    @(negedge clk);
    din_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t6_cnt", 32'(sample_cnt), 32'd3);
`ifdef HIST_MINMAX_EN
    chk("t6_min", 32'(min_code), 32'hFFFF_FFE0);
    chk("t6_max", 32'(max_code), 32'd31);
`else
    chk("t6_min", 32'(min_code), 32'd0);
    chk("t6_max", 32'(max_code), 32'd0);
`endif
    rd_bin(6'd0, d, ds);
    chk("t6_bin0", 32'(d), 32'd1);
    rd_bin(6'd63, d, ds);
    chk("t6_bin63", 32'(d), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hist_monitor.md
Name: hist_monitor

Overview:
- Synthesizable on-chip histogram collector for ADC/FFE/DFE output codes of the time-interleaved baud-rate RX.
- Parametrised successor of the bench-side histogram dump; generalised over slice count, code width, counter width and measurement length.
- Accumulates one selected slice into 2^Nadc saturating bins over a programmed sample count, then serves bin reads through a req/ack port.
- Sits beside the RX datapath in the RX clock domain (clk_rx_rcv).

Parameters:
- Nti, 4, number of interleaved slices on din.
- Nadc, 6, code width per slice (signed two's complement).
- Ncnt, 16, bin counter width.
- Nsamp_log2, 20, samples per measurement = 2^Nsamp_log2.

Ports:
- clk  in  1  RX recovered clock; all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- din  in  Nti*Nadc  packed slice codes; slice k at bits [k*Nadc +: Nadc].
- din_valid  in  1  din qualifier.
- slice_sel  in  max(1,$clog2(Nti))  slice to histogram; sampled on start.
- start  in  1  pulse: clear bins and begin measurement.
- abort  in  1  pulse: stop accumulation, keep partial counts.
- busy  out  1  high in CLEAR or ACCUM.
- done  out  1  high in DONE until next start.
- sat  out  1  sticky: some bin saturated this measurement.
- sample_cnt  out  Nsamp_log2+1  accepted samples this measurement.
- rd_req  in  1  bin read request.
- rd_addr  in  Nadc  bin index.
- rd_ack  out  1  one-cycle read acknowledge.
- rd_data  out  Ncnt  bin count, valid with rd_ack.

Behaviour:
- Reset: state IDLE; all bins 0; busy=0, done=0, sat=0, sample_cnt=0, rd_ack=0, rd_data=0; slice register 0.
- Bin index = code XOR 2^(Nadc-1) (offset binary): code -32 -> bin 0, 0 -> bin 32, +31 -> bin 63 for Nadc=6.
- FSM: IDLE -start-> CLEAR; CLEAR clears one bin per cycle, 2^Nadc cycles, then -> ACCUM; ACCUM -> DONE when sample_cnt reaches 2^Nsamp_log2; DONE -start-> CLEAR; abort in CLEAR/ACCUM -> IDLE (done stays 0, counts and sample_cnt kept).
- start in IDLE/DONE: latches slice_sel, clears sat and sample_cnt, done falls next cycle. start while busy ignored. start and abort same cycle: abort wins.
- Accumulate pipeline: stage 1 registers selected code when din_valid in ACCUM; stage 2 increments bin. Latency 2 cycles from din_valid to updated count. Back-to-back identical codes each count (registers, no RMW hazard). sample_cnt increments in stage 1; samples in stage 1 when ACCUM exits still land in stage 2.
- Counter saturates at 2^Ncnt-1; increment attempted at max sets sat.
- Read: rd_req in IDLE/DONE -> rd_ack=1 and rd_data=bin[rd_addr] next cycle; rd_data holds until next ack. rd_req while busy ignored (no ack). Consecutive rd_req each acked.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- HIST_MINMAX_EN: adds outputs min_code, max_code (signed Nadc), tracked over accepted samples; reset/start set min=+max code, max=-max code. Without macro, ports exist and are driven 0.

Decomposition:
- hist_mon_pkg: state enum (IDLE, CLEAR, ACCUM, DONE), code2bin function, saturating-increment function.
- Sub-module hist_bin_array: 2^Nadc x Ncnt register array with clear-addr, inc-addr, read port, saturation flag.

Test Plan (Nti=4, Nadc=6, Ncnt=16, Nsamp_log2=4):
- Reset, start slice_sel=2, 16 valid cycles slice2=+5 others=-7 -> DONE after 64 clear + 16 + pipeline cycles; bin 37=16, bin 25=0, sample_cnt=16, sat=0.
- din_valid toggling 50% -> only valid cycles counted; done after 16 valids exactly.
- Ncnt=3 override, 16 samples of code 0 -> bin 32=7, sat=1; next start clears sat.
- abort after 6 samples -> IDLE, done=0, sample_cnt=6, bin readable with 6; rd_req during ACCUM gives no rd_ack.
- rstn low mid-ACCUM -> all outputs reset value within same cycle; subsequent reads return 0.
- HIST_MINMAX_EN defined, codes {-32,+31,0} -> min_code=-32, max_code=+31; undefined -> both 0.
